// File: rtl/tlc_timed_2way.sv
// Two-approach timed traffic light controller: road A is main, road B is served on sensor demand.
// Optional all-red clearance phases are compiled in with `define TLC_ALL_RED_EN.
module tlc_timed_2way #(
    parameter int A_GREEN_MIN = 6,
    parameter int B_GREEN_MIN = 5,
    parameter int YELLOW_LEN  = 1,
    parameter int B_GREEN_MAX = 0,
    parameter int CLEAR_LEN   = 2,
    parameter int TW          = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Sa,
    input  logic       Sb,
    output logic       Ra,
    output logic       Ya,
    output logic       Ga,
    output logic       Rb,
    output logic       Yb,
    output logic       Gb,
    output logic [2:0] phase,
    output logic       forced
);

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        A_CLEAR  = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        B_CLEAR  = 3'd5
    } phase_t;

    localparam logic [TW-1:0] A_MIN_LAST = TW'(A_GREEN_MIN - 1);
    localparam logic [TW-1:0] B_MIN_LAST = TW'(B_GREEN_MIN - 1);
    localparam logic [TW-1:0] Y_LAST     = TW'(YELLOW_LEN - 1);
    localparam logic [TW-1:0] C_LAST     = TW'(CLEAR_LEN - 1);
    localparam bit            MAX_EN     = (B_GREEN_MAX != 0);
    localparam logic [TW-1:0] B_MAX_LAST = TW'(MAX_EN ? (B_GREEN_MAX - 1) : 0);
    localparam logic [TW-1:0] TIMER_SAT  = {TW{1'b1}};

`ifdef TLC_ALL_RED_EN
    localparam phase_t AFTER_A_YELLOW = A_CLEAR;
    localparam phase_t AFTER_B_YELLOW = B_CLEAR;
`else
    localparam phase_t AFTER_A_YELLOW = B_GREEN;
    localparam phase_t AFTER_B_YELLOW = A_GREEN;
`endif

    // Lamp pattern {Ra,Ya,Ga,Rb,Yb,Gb} for a phase; clearance and illegal codes show red both ways.
    function automatic logic [5:0] lamp_decode(input phase_t ph);
        logic [5:0] l;
        case (ph)
            A_GREEN:  l = 6'b001_100;
            A_YELLOW: l = 6'b010_100;
            B_GREEN:  l = 6'b100_001;
            B_YELLOW: l = 6'b100_010;
            default:  l = 6'b100_100;
        endcase
        return l;
    endfunction

    phase_t        phase_r;
    phase_t        phase_next_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_next_s;
    logic          forced_r;
    logic          forced_next_s;
    logic [5:0]    lamps_r;
    logic [5:0]    lamps_next_s;
    logic          hold_s;

    // Next-phase, forced-exit flag, timer and lamp computation.
    always_comb begin
        phase_next_s  = phase_r;
        forced_next_s = 1'b0;
        hold_s        = Sb & ~Sa;
        case (phase_r)
            A_GREEN: begin
                if ((timer_r >= A_MIN_LAST) && Sb) phase_next_s = A_YELLOW;
                else                                phase_next_s = A_GREEN;
            end
            A_YELLOW: begin
                if (timer_r >= Y_LAST) phase_next_s = AFTER_A_YELLOW;
                else                   phase_next_s = A_YELLOW;
            end
            A_CLEAR: begin
                if (timer_r >= C_LAST) phase_next_s = B_GREEN;
                else                   phase_next_s = A_CLEAR;
            end
            B_GREEN: begin
                // The max limit wins; it only counts as forced if B still wanted to hold.
                if (MAX_EN && (timer_r >= B_MAX_LAST)) begin
                    phase_next_s  = B_YELLOW;
                    forced_next_s = hold_s;
                end else if ((timer_r >= B_MIN_LAST) && !hold_s) begin
                    phase_next_s = B_YELLOW;
                end else begin
                    phase_next_s = B_GREEN;
                end
            end
            B_YELLOW: begin
                if (timer_r >= Y_LAST) phase_next_s = AFTER_B_YELLOW;
                else                   phase_next_s = B_YELLOW;
            end
            B_CLEAR: begin
                if (timer_r >= C_LAST) phase_next_s = A_GREEN;
                else                   phase_next_s = B_CLEAR;
            end
            default: phase_next_s = A_GREEN;
        endcase

        if (phase_next_s != phase_r)  timer_next_s = {TW{1'b0}};
        else if (timer_r != TIMER_SAT) timer_next_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
        else                           timer_next_s = timer_r;

        lamps_next_s = lamp_decode(phase_next_s);
    end

    // State, timer and registered output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r  <= A_GREEN;
            timer_r  <= {TW{1'b0}};
            forced_r <= 1'b0;
            lamps_r  <= 6'b001_100;
        end else begin
            phase_r  <= phase_next_s;
            timer_r  <= timer_next_s;
            forced_r <= forced_next_s;
            lamps_r  <= lamps_next_s;
        end
    end

    assign {Ra, Ya, Ga, Rb, Yb, Gb} = lamps_r;
    assign phase  = phase_r;
    assign forced = forced_r;

endmodule

// File: tb/tb_tlc_timed_2way.sv
// Table-driven bench for tlc_timed_2way: a default instance and one with B_GREEN_MAX=10.
// Works with or without TLC_ALL_RED_EN; clearance cycles are inserted into the expected tables.
module tb_tlc_timed_2way;

`ifdef TLC_ALL_RED_EN
    localparam int CL = 2;
`else
    localparam int CL = 0;
`endif

    localparam logic [2:0] P_AG = 3'd0;
    localparam logic [2:0] P_AY = 3'd1;
    localparam logic [2:0] P_AC = 3'd2;
    localparam logic [2:0] P_BG = 3'd3;
    localparam logic [2:0] P_BY = 3'd4;
    localparam logic [2:0] P_BC = 3'd5;

    typedef struct {
        logic       sel;
        logic       sa;
        logic       sb;
        logic [2:0] ph;
        logic       fo;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sa = 1'b0;
    logic       sb = 1'b0;
    logic       ra0, ya0, ga0, rb0, yb0, gb0, fo0;
    logic       ra1, ya1, ga1, rb1, yb1, gb1, fo1;
    logic [2:0] ph0, ph1;

    int checks = 0;
    int failures = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    tlc_timed_2way u0 (
        .clk(clk), .reset_n(reset_n), .Sa(sa), .Sb(sb),
        .Ra(ra0), .Ya(ya0), .Ga(ga0), .Rb(rb0), .Yb(yb0), .Gb(gb0),
        .phase(ph0), .forced(fo0)
    );

    tlc_timed_2way #(.B_GREEN_MAX(10)) u1 (
        .clk(clk), .reset_n(reset_n), .Sa(sa), .Sb(sb),
        .Ra(ra1), .Ya(ya1), .Ga(ga1), .Rb(rb1), .Yb(yb1), .Gb(gb1),
        .phase(ph1), .forced(fo1)
    );

    function automatic logic [5:0] exp_lamps(input logic [2:0] ph);
        case (ph)
            P_AG:    return 6'b001_100;
            P_AY:    return 6'b010_100;
            P_BG:    return 6'b100_001;
            P_BY:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic add(input logic sel, input logic a, input logic b,
                       input logic [2:0] ph, input logic fo, input int n);
        vec_t v;
        v.sel = sel; v.sa = a; v.sb = b; v.ph = ph; v.fo = fo;
        for (int k = 0; k < n; k++) vq.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic sel,
                         input logic [2:0] eph, input logic efo);
        logic [2:0] aph;
        logic [5:0] al;
        logic       afo;
        if (sel) begin
            aph = ph1; al = {ra1, ya1, ga1, rb1, yb1, gb1}; afo = fo1;
        end else begin
            aph = ph0; al = {ra0, ya0, ga0, rb0, yb0, gb0}; afo = fo0;
        end
        checks++;
        if (aph !== eph || al !== exp_lamps(eph) || afo !== efo) begin
            failures++;
            $display("FAIL %s[%0d]: got phase=%0d lamps=%b forced=%b, want phase=%0d lamps=%b forced=%b",
                     name, idx, aph, al, afo, eph, exp_lamps(eph), efo);
        end
    endtask

    // Each vector is one cycle: drive sensors at the negedge, check outputs, advance.
    task automatic run_seq(input string name);
        for (int i = 0; i < vq.size(); i++) begin
            sa = vq[i].sa;
            sb = vq[i].sb;
            check(name, i, vq[i].sel, vq[i].ph, vq[i].fo);
            @(negedge clk);
        end
        vq.delete();
    endtask

    // Reset released on a negedge so the following vector is cycle 0 with timer 0.
    task automatic do_reset(input logic sel);
        @(negedge clk);
        reset_n = 1'b0;
        sa = 1'b0;
        sb = 1'b0;
        #1;
        check("reset", 0, sel, P_AG, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #12;

        // Idle: A green forever with no demand.
        do_reset(1'b0);
        add(1'b0, 1'b0, 1'b0, P_AG, 1'b0, 100);
        run_seq("idle");

        // Constant demand on both roads: repeating legacy cycle, never forced.
        do_reset(1'b0);
        for (int p = 0; p < 2; p++) begin
            add(1'b0, 1'b1, 1'b1, P_AG, 1'b0, 6);
            add(1'b0, 1'b1, 1'b1, P_AY, 1'b0, 1);
            add(1'b0, 1'b1, 1'b1, P_AC, 1'b0, CL);
            add(1'b0, 1'b1, 1'b1, P_BG, 1'b0, 5);
            add(1'b0, 1'b1, 1'b1, P_BY, 1'b0, 1);
            add(1'b0, 1'b1, 1'b1, P_BC, 1'b0, CL);
        end
        add(1'b0, 1'b1, 1'b1, P_AG, 1'b0, 1);
        run_seq("period");

        // Late B demand, then B holds past its minimum until Sb drops.
        do_reset(1'b0);
        add(1'b0, 1'b0, 1'b0, P_AG, 1'b0, 20);
        add(1'b0, 1'b0, 1'b1, P_AG, 1'b0, 1);
        add(1'b0, 1'b0, 1'b1, P_AY, 1'b0, 1);
        add(1'b0, 1'b0, 1'b1, P_AC, 1'b0, CL);
        add(1'b0, 1'b0, 1'b1, P_BG, 1'b0, 9);
        add(1'b0, 1'b0, 1'b0, P_BG, 1'b0, 1);
        add(1'b0, 1'b0, 1'b0, P_BY, 1'b0, 1);
        add(1'b0, 1'b0, 1'b0, P_BC, 1'b0, CL);
        add(1'b0, 1'b0, 1'b0, P_AG, 1'b0, 1);
        run_seq("late_sb");

        // Max-green instance: forced exit after 10 cycles, then a voluntary exit.
        do_reset(1'b1);
        add(1'b1, 1'b0, 1'b1, P_AG, 1'b0, 6);
        add(1'b1, 1'b0, 1'b1, P_AY, 1'b0, 1);
        add(1'b1, 1'b0, 1'b1, P_AC, 1'b0, CL);
        add(1'b1, 1'b0, 1'b1, P_BG, 1'b0, 10);
        add(1'b1, 1'b0, 1'b1, P_BY, 1'b1, 1);
        add(1'b1, 1'b0, 1'b1, P_BC, 1'b0, CL);
        add(1'b1, 1'b0, 1'b1, P_AG, 1'b0, 6);
        add(1'b1, 1'b0, 1'b1, P_AY, 1'b0, 1);
        add(1'b1, 1'b0, 1'b1, P_AC, 1'b0, CL);
        add(1'b1, 1'b0, 1'b1, P_BG, 1'b0, 7);
        add(1'b1, 1'b1, 1'b1, P_BG, 1'b0, 1);
        add(1'b1, 1'b0, 1'b0, P_BY, 1'b0, 1);
        add(1'b1, 1'b0, 1'b0, P_BC, 1'b0, CL);
        add(1'b1, 1'b0, 1'b0, P_AG, 1'b0, 1);
        run_seq("max_green");

        // Asynchronous reset at B green timer 3, then a full A green.
        do_reset(1'b0);
        add(1'b0, 1'b0, 1'b1, P_AG, 1'b0, 6);
        add(1'b0, 1'b0, 1'b1, P_AY, 1'b0, 1);
        add(1'b0, 1'b0, 1'b1, P_AC, 1'b0, CL);
        add(1'b0, 1'b0, 1'b1, P_BG, 1'b0, 3);
        run_seq("pre_rst");
        check("mid_bg", 0, 1'b0, P_BG, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst", 0, 1'b0, P_AG, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        add(1'b0, 1'b0, 1'b1, P_AG, 1'b0, 6);
        add(1'b0, 1'b0, 1'b1, P_AY, 1'b0, 1);
        add(1'b0, 1'b0, 1'b1, P_AC, 1'b0, CL);
        add(1'b0, 1'b0, 1'b1, P_BG, 1'b0, 1);
        run_seq("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
